// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock-divider controller.
package clk_div_pkg;

    localparam int PKG_CNT_W   = 4;
    localparam int PKG_RATIO_W = 2;

    // Controller states: stopped, running, running with a change queued
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Ratio codes: code r divides by 2^(r+1)
    localparam logic [PKG_RATIO_W-1:0] R_DIV2  = 2'd0;
    localparam logic [PKG_RATIO_W-1:0] R_DIV4  = 2'd1;
    localparam logic [PKG_RATIO_W-1:0] R_DIV8  = 2'd2;
    localparam logic [PKG_RATIO_W-1:0] R_DIV16 = 2'd3;

    // Terminal count of one period for ratio code r (2^(r+1) - 1)
    function automatic logic [PKG_CNT_W-1:0] ratio_max(input logic [PKG_RATIO_W-1:0] r);
        logic [PKG_CNT_W-1:0] m;
        case (r)
            R_DIV2:  m = 4'd1;
            R_DIV4:  m = 4'd3;
            R_DIV8:  m = 4'd7;
            R_DIV16: m = 4'd15;
            default: m = 4'd15;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, wrap detect and the registered
// divided-clock output. The counter only ever restarts from zero, so
// bits above the active ratio bit stay clear.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int RATIO_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RATIO_W-1:0] active_ratio,
    input  logic               count_en,
    input  logic               clear,
    output logic               wrap,
    output logic               div_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_max;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_max = CNT_W'(ratio_max(PKG_RATIO_W'(active_ratio)));
    assign wrap    = (cnt == cnt_max);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    // Advance the period counter; div_out is the ratio bit of the new count
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt     <= '0;
            div_out <= 1'b0;
        end else if (count_en) begin
            cnt     <= cnt_nxt;
            div_out <= cnt_nxt[active_ratio];
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time controller for the shared clock divider. Configuration arrives
// over a valid/ready handshake and is only applied on a period boundary,
// so div_out never shows a truncated half-period.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int RATIO_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_enable,
    output logic               div_out,
    output logic               tick,
    output logic               run,
    output logic               busy,
    output logic [RATIO_W-1:0] active_ratio
);

    state_t             state;
    logic [RATIO_W-1:0] pend_ratio;
    logic               pend_enable;
    logic               wrap;
    logic               running;
    logic               at_wrap;
    logic               accept;
    logic               apply_now;

    assign running   = (state != OFF);
    assign cfg_ready = ena && rst_n && (state != PEND);
    assign accept    = cfg_valid && cfg_ready;
    assign at_wrap   = running && ena && wrap;
    // A new configuration lands at the wrap: either the queued one or one
    // accepted in the wrap cycle itself; the period restarts from zero.
    assign apply_now = at_wrap && ((state == PEND) || accept);

    assign tick = at_wrap;
    assign run  = running;
    assign busy = (state == PEND);

    clk_div_core #(
        .CNT_W   (CNT_W),
        .RATIO_W (RATIO_W)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_ratio (active_ratio),
        .count_en     (running && ena),
        .clear        (apply_now),
        .wrap         (wrap),
        .div_out      (div_out)
    );

    // Controller FSM: start/stop, queue mid-period requests, apply at wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= OFF;
            active_ratio <= RATIO_W'(R_DIV2);
            pend_ratio   <= RATIO_W'(R_DIV2);
            pend_enable  <= 1'b0;
        end else if (ena) begin
            case (state)
                OFF: begin
                    if (accept && cfg_enable) begin
                        state        <= RUN;
                        active_ratio <= cfg_ratio;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (wrap) begin
                            if (cfg_enable) begin
                                active_ratio <= cfg_ratio;
                            end else begin
                                state <= OFF;
                            end
                        end else begin
                            state       <= PEND;
                            pend_ratio  <= cfg_ratio;
                            pend_enable <= cfg_enable;
                        end
                    end
                end
                PEND: begin
                    if (wrap) begin
                        if (pend_enable) begin
                            state        <= RUN;
                            active_ratio <= pend_ratio;
                        end else begin
                            state <= OFF;
                        end
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed vector table, hand-written
// corner sequences and randomized traffic against a period/phase model.
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ratio;
    logic       cfg_enable;
    logic       div_out;
    logic       tick;
    logic       run;
    logic       busy;
    logic [1:0] active_ratio;

    always #5 clk = ~clk;

    clk_div_sched #(.CNT_W(4), .RATIO_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ratio    (cfg_ratio),
        .cfg_enable   (cfg_enable),
        .div_out      (div_out),
        .tick         (tick),
        .run          (run),
        .busy         (busy),
        .active_ratio (active_ratio)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: divider on/off, change queued, position in period
    bit m_on, m_pend, m_pe;
    int m_phase, m_ratio, m_pr;

    logic       s_div, s_tick, s_run, s_busy, s_ready;
    logic [1:0] s_ar;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic       valid;
        logic [1:0] ratio;
        logic       en;
        logic       div;
        logic       tick;
        logic       run;
        logic       busy;
        logic       ready;
        logic [1:0] ar;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input int r, input bit en);
        if (en) begin
            m_ratio = r;
            m_on    = 1'b1;
        end else begin
            m_on = 1'b0;
        end
        m_pend  = 1'b0;
        m_phase = 0;
    endtask

    task automatic model_step();
        bit acc, wr;
        if (!rst_n) begin
            m_on = 0; m_pend = 0; m_pe = 0;
            m_phase = 0; m_ratio = 0; m_pr = 0;
        end else if (ena) begin
            acc = cfg_valid && !m_pend;
            wr  = m_on && (m_phase == (2 << m_ratio) - 1);
            if (!m_on) begin
                if (acc && cfg_enable) model_apply(int'(cfg_ratio), 1'b1);
            end else if (m_pend) begin
                if (wr) model_apply(m_pr, m_pe);
                else    m_phase++;
            end else if (acc) begin
                if (wr) model_apply(int'(cfg_ratio), cfg_enable);
                else begin
                    m_pend  = 1'b1;
                    m_pr    = int'(cfg_ratio);
                    m_pe    = cfg_enable;
                    m_phase++;
                end
            end else begin
                m_phase = wr ? 0 : m_phase + 1;
            end
        end
    endtask

    // One clock: sample and check on the falling edge, advance the model on the rising edge
    task automatic cycle();
        @(negedge clk);
        s_div = div_out; s_tick = tick; s_run = run;
        s_busy = busy; s_ready = cfg_ready; s_ar = active_ratio;
        if (chk_en) begin
            chk("model_div",   32'(s_div),   32'(m_on && (m_phase >= (1 << m_ratio))));
            chk("model_tick",  32'(s_tick),  32'(m_on && ena && (m_phase == (2 << m_ratio) - 1)));
            chk("model_ready", 32'(s_ready), 32'(ena && rst_n && !m_pend));
            chk("model_run",   32'(s_run),   32'(m_on));
            chk("model_busy",  32'(s_busy),  32'(m_pend));
            chk("model_ratio", 32'(s_ar),    32'(m_ratio));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] r, input logic en);
        cfg_valid = 1'b1; cfg_ratio = r; cfg_enable = en;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] busy_seq, div_seq;
        int first_tick;
        logic [5:0] e_ready, e_busy;

        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_ratio = 2'd0; cfg_enable = 1'b0;
        cycle();
        cycle();
        chk_en = 1'b1;

        // rst ena vld ratio en | div tick run busy ready ar   (pre-edge values)
        tbl[0] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

        for (int i = 0; i < 9; i++) begin
            rst_n = tbl[i].rst_n; ena = tbl[i].ena; cfg_valid = tbl[i].valid;
            cfg_ratio = tbl[i].ratio; cfg_enable = tbl[i].en;
            cycle();
            chk($sformatf("tbl%0d_div", i),   32'(s_div),   32'(tbl[i].div));
            chk($sformatf("tbl%0d_tick", i),  32'(s_tick),  32'(tbl[i].tick));
            chk($sformatf("tbl%0d_run", i),   32'(s_run),   32'(tbl[i].run));
            chk($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(tbl[i].busy));
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_ar", i),    32'(s_ar),    32'(tbl[i].ar));
        end
        cfg_valid = 1'b0;

        // /4 running, switch to /16 requested at cnt=1
        do_reset();
        send(2'd1, 1'b1);
        cycle();
        cfg_valid = 1'b1; cfg_ratio = 2'd3; cfg_enable = 1'b1;
        cycle();
        chk("a_ready_at_cnt1", 32'(s_ready), 32'd1);
        cfg_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cycle();
            busy_seq[i] = s_busy;
            div_seq[i]  = s_div;
        end
        chk("a_busy_seq", 32'(busy_seq), 32'h00003);
        chk("a_div_seq",  32'(div_seq[17:2]), 32'hFF00);

        // /8 running, disable exactly in the wrap cycle
        do_reset();
        send(2'd2, 1'b1);
        for (int i = 0; i < 7; i++) cycle();
        cfg_valid = 1'b1; cfg_ratio = 2'd0; cfg_enable = 1'b0;
        cycle();
        chk("b_tick_wrap",  32'(s_tick),  32'd1);
        chk("b_ready_wrap", 32'(s_ready), 32'd1);
        cfg_valid = 1'b0;
        cycle();
        chk("b_run_off",  32'(s_run),  32'd0);
        chk("b_div_off",  32'(s_div),  32'd0);
        chk("b_busy_off", 32'(s_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("b_tick_off", 32'(s_tick), 32'd0);
        end

        // /16 running, ena dropped at cnt=5 for 10 cycles
        do_reset();
        send(2'd3, 1'b1);
        for (int i = 0; i < 5; i++) cycle();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("c_tick_frozen",  32'(s_tick),  32'd0);
            chk("c_ready_frozen", 32'(s_ready), 32'd0);
            chk("c_run_frozen",   32'(s_run),   32'd1);
            chk("c_div_frozen",   32'(s_div),   32'd0);
        end
        ena = 1'b1;
        first_tick = -1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (s_tick && first_tick < 0) first_tick = i;
        end
        chk("c_first_tick_after_resume", 32'(first_tick), 32'd10);

        // reset while a change is pending
        do_reset();
        send(2'd2, 1'b1);
        cfg_valid = 1'b1; cfg_ratio = 2'd3; cfg_enable = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        chk("d_busy_pend", 32'(s_busy), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("d_rst_run",   32'(s_run),   32'd0);
        chk("d_rst_busy",  32'(s_busy),  32'd0);
        chk("d_rst_div",   32'(s_div),   32'd0);
        chk("d_rst_tick",  32'(s_tick),  32'd0);
        chk("d_rst_ar",    32'(s_ar),    32'd0);
        chk("d_rst_ready", 32'(s_ready), 32'd1);
        send(2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("d_restart_ar",   32'(s_ar),   32'd0);
            chk("d_restart_busy", 32'(s_busy), 32'd0);
            chk("d_restart_div",  32'(s_div),  32'(i % 2));
        end

        // cfg_valid held through PEND: re-accepted right after the apply
        do_reset();
        send(2'd1, 1'b1);
        cfg_valid = 1'b1; cfg_ratio = 2'd2; cfg_enable = 1'b1;
        e_ready = 6'b010001;
        e_busy  = 6'b101110;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("e_ready%0d", i), 32'(s_ready), 32'(e_ready[i]));
            chk($sformatf("e_busy%0d", i),  32'(s_busy),  32'(e_busy[i]));
            chk($sformatf("e_ar%0d", i),    32'(s_ar),    (i >= 4) ? 32'd2 : 32'd1);
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            ena        = ($urandom_range(0, 4) != 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ratio  = 2'($urandom_range(0, 3));
            cfg_enable = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
